// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: client status codes, length codes and FSM states for the byte-serial memory controller
package mem_ctrl_pkg;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] BUSY  = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;
    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    function automatic logic [2:0] nbytes(input logic [1:0] len);
        return len == LEN_B ? 3'd1 : len == LEN_H ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating IF word fetches and MEM byte/half/word loads and stores
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [1:0]        if_status,
    output logic [DATA_W-1:0] if_data,
    input  logic              mm_req,
    input  logic              mm_we,
    input  logic [1:0]        mm_len,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic [DATA_W-1:0] mm_wdata,
    output logic [1:0]        mm_status,
    output logic [DATA_W-1:0] mm_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              icache_we,
    output logic [ADDR_W-1:0] icache_addr,
    output logic [DATA_W-1:0] icache_data
);
    state_t state, nxt;
    logic [2:0] cnt, n;
    logic is_mm, sel_mm, busy_nxt;
    logic [1:0] idx, if_st, mm_st;
    logic [DATA_W-1:0] wbuf, rbuf, asm;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = mm_req ? (mm_we ? S_WR : S_RD) : if_req ? S_RD : S_IDLE;
            S_RD:    nxt = cnt == n ? S_DONE : S_RD;
            S_WR:    nxt = cnt == n - 3'd1 ? S_DONE : S_WR;
            default: nxt = S_IDLE;
        endcase
        sel_mm   = state == S_IDLE ? mm_req : is_mm;
        busy_nxt = nxt == S_RD || nxt == S_WR;
        if_st = (nxt == S_DONE && !sel_mm) ? DONE : ((busy_nxt && !sel_mm) || if_req) ? BUSY : IDLE;
        mm_st = (nxt == S_DONE && sel_mm) ? DONE : ((busy_nxt && sel_mm) || mm_req) ? BUSY : IDLE;
        // the byte on ram_din belongs to the address issued one cycle earlier
        idx = cnt[1:0] - 2'd1;
        asm = rbuf;
        asm[{idx, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if_status   <= IDLE;
            mm_status   <= IDLE;
            if_data     <= '0;
            mm_rdata    <= '0;
            ram_a       <= '0;
            ram_dout    <= '0;
            ram_wr      <= 1'b0;
            icache_we   <= 1'b0;
            icache_addr <= '0;
            icache_data <= '0;
            cnt         <= '0;
            n           <= '0;
            is_mm       <= 1'b0;
            wbuf        <= '0;
            rbuf        <= '0;
        end else begin
            if_status <= if_st;
            mm_status <= mm_st;
            icache_we <= 1'b0;
            case (state)
                S_IDLE: if (mm_req || if_req) begin
                    is_mm    <= mm_req;
                    n        <= mm_req ? nbytes(mm_len) : 3'd4;
                    cnt      <= '0;
                    ram_a    <= mm_req ? mm_addr : if_addr;
                    ram_wr   <= mm_req && mm_we;
                    ram_dout <= mm_wdata[7:0];
                    wbuf     <= mm_wdata;
                    rbuf     <= '0;
                    if (!mm_req) icache_addr <= if_addr;
                end
                S_RD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt != 3'd0) rbuf <= asm;
                    if (cnt < n - 3'd1) ram_a <= ram_a + 1'b1;
                    if (cnt == n) begin
                        if (is_mm) mm_rdata <= asm;
                        else begin
                            if_data     <= asm;
                            icache_data <= asm;
                            icache_we   <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == n - 3'd1) ram_wr <= 1'b0;
                    else begin
                        ram_a    <= ram_a + 1'b1;
                        ram_dout <= wbuf[15:8];
                        wbuf     <= wbuf >> 8;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and random transfers against a byte-array RAM and a transaction-level model
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0, rst;
    logic        if_req, mm_req, mm_we;
    logic [1:0]  mm_len, if_status, mm_status;
    logic [31:0] if_addr, mm_addr, mm_wdata, if_data, mm_rdata, ram_a, icache_addr, icache_data;
    logic [7:0]  ram_din, ram_dout;
    logic        ram_wr, icache_we;
    logic [7:0]  mem [0:4095];
    int          tests = 0, failed = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_status(if_status), .if_data(if_data),
        .mm_req(mm_req), .mm_we(mm_we), .mm_len(mm_len), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_status(mm_status), .mm_rdata(mm_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .icache_we(icache_we), .icache_addr(icache_addr), .icache_data(icache_data)
    );

    always #5 clk = ~clk;

    // 4 KiB RAM aliased on the low address bits; one-cycle read latency
    always @(posedge clk) begin
        ram_din <= mem[ram_a[11:0]];
        if (ram_wr) mem[ram_a[11:0]] <= ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_if_status", if_status, IDLE);
        chk("rst_mm_status", mm_status, IDLE);
        chk("rst_if_data", if_data, 0);
        chk("rst_mm_rdata", mm_rdata, 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_dout", ram_dout, 0);
        chk("rst_ram_wr", ram_wr, 0);
        chk("rst_icache_we", icache_we, 0);
    endtask

    task automatic xfer(input bit mm, input bit we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        int n, lat;
        logic [31:0] a, exp;
        logic [31:0] a_seq[$];
        logic w_seq[$];
        logic [7:0] after;
        n = len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4;
        exp = '0;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            exp[8*k +: 8] = mem[a[11:0]];
        end
        a = addr + n;
        after = mem[a[11:0]];
        if (mm) begin
            mm_req = 1'b1; mm_we = we; mm_len = len; mm_addr = addr; mm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            a_seq.push_back(ram_a);
            w_seq.push_back(ram_wr);
        end while ((mm ? mm_status : if_status) !== DONE && lat < 40);
        chk("latency", lat, (mm && we) ? n + 1 : n + 2);
        for (int k = 0; k < n && k < a_seq.size(); k++) begin
            chk("ram_a", a_seq[k], addr + k);
            chk("ram_wr", w_seq[k], mm && we);
        end
        if (mm && we) chk("ram_wr_drop", w_seq[n], 0);
        else chk("rdata", mm ? mm_rdata : if_data, exp);
        if (!mm) begin
            chk("icache_we", icache_we, 1);
            chk("icache_addr", icache_addr, addr);
            chk("icache_data", icache_data, exp);
        end
        if (!hold) begin
            if (mm) mm_req = 1'b0;
            else if_req = 1'b0;
        end
        @(negedge clk);
        chk("single_done", mm ? mm_status : if_status, hold ? BUSY : IDLE);
        chk("icache_we_pulse", icache_we, 0);
        if (mm && we) begin
            for (int k = 0; k < n; k++) begin
                a = addr + k;
                chk("store_byte", mem[a[11:0]], wd[8*k +: 8]);
            end
            a = addr + n;
            chk("store_untouched", mem[a[11:0]], after);
        end
    endtask

    initial begin
        logic [31:0] ra;
        bit rmm, rwe;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11);
        rst = 1'b0; if_req = 1'b0; mm_req = 1'b0; mm_we = 1'b0; mm_len = 2'd0;
        if_addr = '0; mm_addr = '0; mm_wdata = '0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b1;
        @(negedge clk);

        mem[12'h100] = 8'h13; mem[12'h101] = 8'h05; mem[12'h102] = 8'h10; mem[12'h103] = 8'h00;
        xfer(0, 0, LEN_W, 32'h100, 0, 0);
        chk("fetch_word", if_data, 32'h00100513);

        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) @(negedge clk);
        rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk_reset();
        @(negedge clk);
        chk_reset();
        rst = 1'b1;
        @(negedge clk);
        xfer(0, 0, LEN_W, 32'h100, 0, 0);

        mem[12'h001] = 8'hFF;
        if_req = 1'b1; if_addr = 32'h200;
        xfer(1, 0, LEN_B, 32'h2001, 0, 0);
        chk("contend_mm_rdata", mm_rdata, 32'h000000FF);
        chk("contend_if_busy", if_status, BUSY);
        xfer(0, 0, LEN_W, 32'h200, 0, 0);

        xfer(1, 1, LEN_H, 32'h3000, 32'hAABBCCDD, 0);
        chk("store_half_lo", mem[12'h000], 8'hDD);
        chk("store_half_hi", mem[12'h001], 8'hCC);

        xfer(1, 0, LEN_W, 32'hFFFFFFFE, 0, 0);

        xfer(0, 0, LEN_W, 32'h400, 0, 1);
        xfer(0, 0, LEN_W, 32'h400, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ra  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                              : 32'h4000 + $urandom_range(0, 255);
            rmm = 1'($urandom_range(0, 2) != 0);
            rwe = 1'($urandom_range(0, 1));
            if (rmm) xfer(1, rwe, 2'($urandom_range(0, 3)), ra, $urandom, 0);
            else     xfer(0, 0, LEN_W, ra & ~32'h3, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
